// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the SESO fetch unit: run/halt states, opcode encodings
// and branch-target LUT geometry.
package fetch_unit_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;

  localparam int unsigned kOpW = 4;

  localparam logic [kOpW-1:0] kADD     = 4'b0000;
  localparam logic [kOpW-1:0] kCMP     = 4'b0010;
  localparam logic [kOpW-1:0] kB       = 4'b1011;
  localparam logic [kOpW-1:0] kBEQ     = 4'b1100;
  localparam logic [kOpW-1:0] kBNE     = 4'b1101;
  localparam logic [kOpW-1:0] kHALT    = 4'b1110;
  localparam logic [kOpW-1:0] kIllegal = 4'b1111;

  localparam int unsigned kBrLutDepth = 32;
  localparam int unsigned kBrIdxW     = $clog2(kBrLutDepth);

  // Largest target held in the branch LUT; bounds the smallest usable PC width.
  localparam int unsigned kBrMaxTarget = 15;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target ROM: maps a 5-bit operand to an absolute PC. Unlisted indices
// return address 0.
module fetch_unit_branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [kBrIdxW-1:0] index,
  output logic [PC_W-1:0]    target
);

  if (kBrMaxTarget >= (1 << PC_W)) begin : gTargetCheck
    $error("branch LUT target does not fit in PC_W bits");
  end

  always_comb begin
    target = '0;
    case (index)
      5'd1:    target = PC_W'(12);
      5'd2:    target = PC_W'(10);
      5'd3:    target = PC_W'(3);
      5'd7:    target = PC_W'(15);
      5'd12:   target = PC_W'(1);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, next-PC resolution and run/halt sequencing for the SESO core.
// Splits the ROM word into Opcode/Operand for the decoder and ALU.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_DEPTH = 32,
  parameter int unsigned CYC_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               ZeroFlag,
  output logic [PC_W-1:0]    PC,
  output logic [3:0]         Opcode,
  output logic [4:0]         Operand,
  output logic               InstrValid,
  output logic               Done,
  output logic               IllegalOp,
  output logic [CYC_W-1:0]   CycleCount
);

  if (LUT_DEPTH != kBrLutDepth || INSTR_W != 9) begin : gGeometryCheck
    $error("fetch_unit supports only a 32-entry LUT and 9-bit instructions");
  end

  fetch_state_e       state;
  fetch_state_e       nextState;
  logic [PC_W-1:0]    pcNext;
  logic [PC_W-1:0]    pcPlusOne;
  logic [PC_W-1:0]    lutTarget;
  logic [CYC_W-1:0]   cycNext;
  logic               illegalNext;

  // Outside RUN the decoder sees a HALT so no downstream state is disturbed.
  assign InstrValid = (state == RUN);
  assign Done       = (state == HALTED);
  assign Opcode     = InstrValid ? Instr[8:5] : kHALT;
  assign Operand    = InstrValid ? Instr[4:0] : 5'd0;
  assign pcPlusOne  = PC + PC_W'(1);

  fetch_unit_branch_lut #(
    .PC_W (PC_W)
  ) uBranchLut (
    .index  (Operand),
    .target (lutTarget)
  );

  always_comb begin
    nextState   = state;
    pcNext      = PC;
    cycNext     = CycleCount;
    illegalNext = IllegalOp;
    case (state)
      IDLE, HALTED: begin
        if (Start) begin
          nextState   = RUN;
          pcNext      = '0;
          cycNext     = '0;
          illegalNext = 1'b0;
        end
      end
      RUN: begin
        if (!(&CycleCount)) cycNext = CycleCount + CYC_W'(1);
        // ZeroFlag is taken as seen this cycle, so a CMP right before a branch counts.
        case (Opcode)
          kB:       pcNext = lutTarget;
          kBEQ:     pcNext = ZeroFlag ? lutTarget : pcPlusOne;
          kBNE:     pcNext = ZeroFlag ? pcPlusOne : lutTarget;
          kHALT:    nextState = HALTED;
          kIllegal: begin
            illegalNext = 1'b1;
            pcNext      = pcPlusOne;
          end
          default:  pcNext = pcPlusOne;
        endcase
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= '0;
      CycleCount <= '0;
      IllegalOp  <= 1'b0;
    end else begin
      state      <= nextState;
      PC         <= pcNext;
      CycleCount <= cycNext;
      IllegalOp  <= illegalNext;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and
// a randomized run against a behavioural program-execution model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned PcDepth = 1024;
  localparam int unsigned CycMax  = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance (PC_W=10)
  logic        resetA, startA, zeroA;
  logic [8:0]  instrA;
  logic [8:0]  romA [PcDepth];
  logic [9:0]  pcA;
  logic [3:0]  opcodeA;
  logic [4:0]  operandA;
  logic        validA, doneA, illA;
  logic [15:0] cycA;

  assign instrA = romA[pcA];

  fetch_unit #(.PC_W(10), .INSTR_W(9), .LUT_DEPTH(32), .CYC_W(16)) dutA (
    .Clk(clk), .Reset(resetA), .Start(startA), .Instr(instrA), .ZeroFlag(zeroA),
    .PC(pcA), .Opcode(opcodeA), .Operand(operandA), .InstrValid(validA),
    .Done(doneA), .IllegalOp(illA), .CycleCount(cycA)
  );

  // Narrow instance for PC wrap and cycle-counter saturation
  logic        resetB, startB, zeroB;
  logic [8:0]  instrB;
  logic [3:0]  pcB;
  logic [3:0]  opcodeB;
  logic [4:0]  operandB;
  logic        validB, doneB, illB;
  logic [5:0]  cycB;

  assign instrB = {kADD, 5'd3};
  assign zeroB  = 1'b0;

  fetch_unit #(.PC_W(4), .INSTR_W(9), .LUT_DEPTH(32), .CYC_W(6)) dutB (
    .Clk(clk), .Reset(resetB), .Start(startB), .Instr(instrB), .ZeroFlag(zeroB),
    .PC(pcB), .Opcode(opcodeB), .Operand(operandB), .InstrValid(validB),
    .Done(doneB), .IllegalOp(illB), .CycleCount(cycB)
  );

  int unsigned lutRef [32];

  typedef struct {
    int unsigned pc;
    logic [3:0]  op;
    logic [4:0]  opnd;
    logic        zf;
    int unsigned expPc;
    logic        expIll;
    logic        expDone;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadNops();
    for (int i = 0; i < int'(PcDepth); i++) romA[i] = {kADD, 5'(i)};
  endtask

  task automatic resetPulseA();
    resetA = 1'b1;
    startA = 1'b0;
    zeroA  = 1'b0;
    tick();
    resetA = 1'b0;
    tick();
  endtask

  task automatic launchA();
    startA = 1'b1;
    tick();
    startA = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mState, mPc, mCyc, tgt;
    logic        mIll;
    logic [8:0]  w;
    logic [3:0]  op;

    resetA = 1'b1; startA = 1'b0; zeroA = 1'b0;
    resetB = 1'b1; startB = 1'b0;
    loadNops();
    for (int i = 0; i < 32; i++) lutRef[i] = 0;
    lutRef[1] = 12; lutRef[2] = 10; lutRef[3] = 3; lutRef[7] = 15; lutRef[12] = 1;

    vecs.push_back('{5, kBEQ,     5'd2,  1'b1, 10, 1'b0, 1'b0});
    vecs.push_back('{5, kBEQ,     5'd2,  1'b0, 6,  1'b0, 1'b0});
    vecs.push_back('{5, kBNE,     5'd2,  1'b0, 10, 1'b0, 1'b0});
    vecs.push_back('{5, kBNE,     5'd2,  1'b1, 6,  1'b0, 1'b0});
    vecs.push_back('{4, kB,       5'd1,  1'b0, 12, 1'b0, 1'b0});
    vecs.push_back('{6, kB,       5'd9,  1'b1, 0,  1'b0, 1'b0});
    vecs.push_back('{3, kB,       5'd3,  1'b0, 3,  1'b0, 1'b0});
    vecs.push_back('{7, kIllegal, 5'd0,  1'b0, 8,  1'b1, 1'b0});
    vecs.push_back('{3, kHALT,    5'd0,  1'b0, 3,  1'b0, 1'b1});
    vecs.push_back('{8, kCMP,     5'd2,  1'b1, 9,  1'b0, 1'b0});
    vecs.push_back('{2, kB,       5'd7,  1'b0, 15, 1'b0, 1'b0});
    vecs.push_back('{9, kBEQ,     5'd12, 1'b1, 1,  1'b0, 1'b0});

    // Reset held, then idle with Start low
    tick();
    check("rst_pc", 32'(pcA), 32'd0);
    check("rst_valid", 32'(validA), 32'd0);
    resetA = 1'b0;
    repeat (5) tick();
    check("idle_pc", 32'(pcA), 32'd0);
    check("idle_done", 32'(doneA), 32'd0);
    check("idle_valid", 32'(validA), 32'd0);
    check("idle_cyc", 32'(cycA), 32'd0);
    check("idle_opcode", 32'(opcodeA), 32'(kHALT));
    check("idle_operand", 32'(operandA), 32'd0);

    // Straight-line program ending in HALT, then restart from HALTED
    loadNops();
    romA[3] = {kHALT, 5'd0};
    launchA();
    for (int i = 0; i < 4; i++) begin
      check("run_pc", 32'(pcA), 32'(i));
      check("run_valid", 32'(validA), 32'd1);
      tick();
    end
    check("halt_done", 32'(doneA), 32'd1);
    check("halt_pc", 32'(pcA), 32'd3);
    check("halt_cyc", 32'(cycA), 32'd4);
    check("halt_valid", 32'(validA), 32'd0);
    repeat (3) tick();
    check("halt_hold_pc", 32'(pcA), 32'd3);
    check("halt_hold_cyc", 32'(cycA), 32'd4);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    check("restart_pc", 32'(pcA), 32'd0);
    check("restart_cyc", 32'(cycA), 32'd0);
    check("restart_done", 32'(doneA), 32'd0);
    check("restart_valid", 32'(validA), 32'd1);

    // Single-instruction vectors placed at a chosen PC
    foreach (vecs[v]) begin
      resetPulseA();
      loadNops();
      romA[vecs[v].pc] = {vecs[v].op, vecs[v].opnd};
      launchA();
      repeat (vecs[v].pc) tick();
      check("vec_pre_pc", 32'(pcA), 32'(vecs[v].pc));
      zeroA = vecs[v].zf;
      tick();
      zeroA = 1'b0;
      check("vec_pc", 32'(pcA), 32'(vecs[v].expPc));
      check("vec_ill", 32'(illA), 32'(vecs[v].expIll));
      check("vec_done", 32'(doneA), 32'(vecs[v].expDone));
      check("vec_cyc", 32'(cycA), 32'(vecs[v].pc + 1));
    end

    // IllegalOp is sticky through HALTED and cleared by the next Start
    resetPulseA();
    loadNops();
    romA[7]  = {kIllegal, 5'd0};
    romA[12] = {kHALT, 5'd0};
    launchA();
    repeat (7) tick();
    check("ill_before", 32'(illA), 32'd0);
    tick();
    check("ill_set", 32'(illA), 32'd1);
    check("ill_pc", 32'(pcA), 32'd8);
    repeat (4) tick();
    check("ill_sticky", 32'(illA), 32'd1);
    tick();
    check("ill_halt_done", 32'(doneA), 32'd1);
    check("ill_halt_keep", 32'(illA), 32'd1);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    check("ill_cleared", 32'(illA), 32'd0);
    check("ill_restart_pc", 32'(pcA), 32'd0);

    // Start ignored while running; async reset mid-run
    resetPulseA();
    loadNops();
    launchA();
    startA = 1'b1;
    repeat (9) tick();
    startA = 1'b0;
    check("start_ignored_pc", 32'(pcA), 32'd9);
    resetA = 1'b1;
    #1;
    check("async_rst_pc", 32'(pcA), 32'd0);
    check("async_rst_valid", 32'(validA), 32'd0);
    check("async_rst_cyc", 32'(cycA), 32'd0);
    tick();
    resetA = 1'b0;
    tick();
    check("post_rst_idle_pc", 32'(pcA), 32'd0);
    check("post_rst_idle_valid", 32'(validA), 32'd0);

    // Narrow instance: PC wraps 15 -> 0, counter saturates at 63
    tick();
    resetB = 1'b0;
    startB = 1'b1;
    tick();
    startB = 1'b0;
    for (int i = 0; i < 70; i++) begin
      check("wrap_pc", 32'(pcB), 32'(i % 16));
      tick();
    end
    check("wrap_pc_end", 32'(pcB), 32'd6);
    check("sat_cyc", 32'(cycB), 32'd63);
    check("wrap_ill", 32'(illB), 32'd0);
    check("wrap_done", 32'(doneB), 32'd0);
    check("wrap_valid", 32'(validB), 32'd1);
    check("wrap_opcode", 32'(opcodeB), 32'(kADD));
    check("wrap_operand", 32'(operandB), 32'd3);

    // Randomized programs against an execution model
    resetPulseA();
    for (int i = 0; i < int'(PcDepth); i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == kHALT && $urandom_range(0, 3) != 0) op = kADD;
      romA[i] = {op, 5'($urandom_range(0, 31))};
    end
    mState = 0; mPc = 0; mCyc = 0; mIll = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      startA = ($urandom_range(0, 9) < 2);
      zeroA  = 1'($urandom_range(0, 1));
      if (mState != 1) begin
        if (startA) begin
          mState = 1; mPc = 0; mCyc = 0; mIll = 1'b0;
        end
      end else begin
        w   = romA[mPc];
        op  = w[8:5];
        tgt = lutRef[w[4:0]];
        if (mCyc < CycMax) mCyc = mCyc + 1;
        if (op == kB) mPc = tgt;
        else if (op == kBEQ) mPc = zeroA ? tgt : (mPc + 1) % PcDepth;
        else if (op == kBNE) mPc = zeroA ? (mPc + 1) % PcDepth : tgt;
        else if (op == kHALT) mState = 2;
        else begin
          if (op == kIllegal) mIll = 1'b1;
          mPc = (mPc + 1) % PcDepth;
        end
      end
      tick();
      w = romA[mPc];
      check("rnd_pc", 32'(pcA), 32'(mPc));
      check("rnd_valid", 32'(validA), 32'(mState == 1));
      check("rnd_done", 32'(doneA), 32'(mState == 2));
      check("rnd_cyc", 32'(cycA), 32'(mCyc));
      check("rnd_ill", 32'(illA), 32'(mIll));
      check("rnd_opcode", 32'(opcodeA), (mState == 1) ? 32'(w[8:5]) : 32'(kHALT));
      check("rnd_operand", 32'(operandA), (mState == 1) ? 32'(w[4:0]) : 32'd0);
    end
    startA = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
